// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler
// Owns the single port of the 2-bit branch-predictor counter table. It
// arbitrates fetch lookups against ROB training updates. Updates are queued
// in a small FIFO and applied as a read followed by a write. After reset the
// table is swept to weakly-not-taken. A starvation counter bounds how long
// fetch may keep the queued work off the port.
// Optional feature macro: BP_STATS_EN adds push statistics counters. When it
// is undefined, the statistics outputs are tied to zero.
module bp_update_scheduler #(
    parameter int DEPTH        = 4,
    parameter int IDXW         = 8,
    parameter int STARVE_LIMIT = 3,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            fet_req,
    input  logic [XLEN-1:0] fet_pc,
    output logic            fet_gnt,
    input  logic            rob_bp_enable,
    input  logic [XLEN-1:0] rob_bp_inst_addr,
    input  logic            rob_bp_jump,
    input  logic            rob_bp_correct,
    output logic            sch_full,
    output logic            tbl_req,
    output logic            tbl_we,
    output logic [IDXW-1:0] tbl_idx,
    output logic [1:0]      tbl_wdata,
    input  logic [1:0]      tbl_rdata,
    output logic [XLEN-1:0] bp_total_cnt,
    output logic [XLEN-1:0] bp_correct_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic jump);
        logic [1:0] res;
        if (jump) begin
            if (cur != 2'b11) res = cur + 2'b01;
            else              res = cur;
        end else begin
            if (cur != 2'b00) res = cur - 2'b01;
            else              res = cur;
        end
        return res;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDXW-1:0] sweep_r;
    logic [IDXW-1:0] idx_mem_r [DEPTH];
    logic            jump_mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW:0]     count_r;
    logic [SW-1:0]   starve_r;
    logic [1:0]      hold_r;
    logic            wr_first_r;

    logic [IDXW-1:0] head_idx_s;
    logic            head_jump_s;
    logic [1:0]      cur_val_s;
    logic [1:0]      new_val_s;
    logic            pending_s;
    logic            grant_s;
    logic            push_s;
    logic            pop_s;
    logic            unused_s;

    // Address bits outside the index field do not affect the table.
    assign unused_s = ^{fet_pc[XLEN-1:IDXW+1], fet_pc[0],
                        rob_bp_inst_addr[XLEN-1:IDXW+1], rob_bp_inst_addr[0],
                        rob_bp_correct};

    assign head_idx_s  = idx_mem_r[rd_ptr_r];
    assign head_jump_s = jump_mem_r[rd_ptr_r];
    assign sch_full    = rst || (state_r == ST_INIT) || (count_r == (AW+1)'(DEPTH));
    assign pending_s   = ((state_r == ST_IDLE) && (count_r != '0)) || (state_r == ST_WR);
    assign grant_s     = pending_s && (!fet_req || (starve_r == SW'(STARVE_LIMIT)));
    assign push_s      = !rst && rdy && rob_bp_enable && !flush && !sch_full;
    assign pop_s       = !rst && rdy && grant_s && (state_r == ST_WR);

    // Read data is live on the first WR cycle. Later cycles use the captured
    // copy because fetch may have used the port in between.
    always_comb begin
        cur_val_s = 2'b00;
        if (wr_first_r) cur_val_s = tbl_rdata;
        else            cur_val_s = hold_r;
        new_val_s = sat_update(cur_val_s, head_jump_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)      state_r <= ST_INIT;
        else if (rdy) state_r <= state_nxt_s;
        else          state_r <= state_r;
    end

    // Next-state logic and table port arbitration.
    always_comb begin
        state_nxt_s = state_r;
        tbl_req     = 1'b0;
        tbl_we      = 1'b0;
        tbl_idx     = '0;
        tbl_wdata   = 2'b00;
        fet_gnt     = 1'b0;
        if (rst) begin
            tbl_req   = 1'b1;
            tbl_we    = 1'b1;
            tbl_wdata = 2'b01;
        end else if (!rdy) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_INIT: begin
                    tbl_req   = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_idx   = sweep_r;
                    tbl_wdata = 2'b01;
                    if (sweep_r == {IDXW{1'b1}}) state_nxt_s = ST_IDLE;
                    else                         state_nxt_s = ST_INIT;
                end
                ST_IDLE, ST_WR: begin
                    if (grant_s) begin
                        tbl_req = 1'b1;
                        tbl_idx = head_idx_s;
                        if (state_r == ST_WR) begin
                            tbl_we      = 1'b1;
                            tbl_wdata   = new_val_s;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_WR;
                        end
                    end else if (fet_req) begin
                        fet_gnt = 1'b1;
                        tbl_req = 1'b1;
                        tbl_idx = fet_pc[IDXW:1];
                    end else begin
                        tbl_req = 1'b0;
                    end
                end
                default: state_nxt_s = ST_INIT;
            endcase
        end
    end

    // Sweep index for the post-reset table initialisation.
    always_ff @(posedge clk) begin
        if (rst)                             sweep_r <= '0;
        else if (rdy && state_r == ST_INIT)  sweep_r <= sweep_r + {{(IDXW-1){1'b0}}, 1'b1};
        else                                 sweep_r <= sweep_r;
    end

    // FIFO storage. Contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            idx_mem_r[wr_ptr_r]  <= rob_bp_inst_addr[IDXW:1];
            jump_mem_r[wr_ptr_r] <= rob_bp_jump;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: counts denied cycles of a pending operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= '0;
        end else if (rdy && pending_s) begin
            if (grant_s)                              starve_r <= '0;
            else if (starve_r != SW'(STARVE_LIMIT))   starve_r <= starve_r + {{(SW-1){1'b0}}, 1'b1};
            else                                      starve_r <= starve_r;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Capture the read result on the first WR cycle and hold it until the write is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r     <= 2'b00;
            wr_first_r <= 1'b0;
        end else if (rdy) begin
            if (state_r == ST_IDLE && grant_s) begin
                wr_first_r <= 1'b1;
            end else if (state_r == ST_WR && wr_first_r) begin
                hold_r     <= tbl_rdata;
                wr_first_r <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [XLEN-1:0] total_r;
    logic [XLEN-1:0] correct_r;

    // Statistics on accepted pushes; both counters wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_r   <= '0;
            correct_r <= '0;
        end else if (push_s) begin
            total_r <= total_r + {{(XLEN-1){1'b0}}, 1'b1};
            if (rob_bp_correct) correct_r <= correct_r + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    assign bp_total_cnt   = total_r;
    assign bp_correct_cnt = correct_r;
`else
    assign bp_total_cnt   = '0;
    assign bp_correct_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with IDXW=4. A behavioural
// single-port table sits on the tbl_* port. Expected values are hand-computed.
module tb_bp_update_scheduler;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        fet_req;
    logic [31:0] fet_pc;
    logic        fet_gnt;
    logic        rob_bp_enable;
    logic [31:0] rob_bp_inst_addr;
    logic        rob_bp_jump;
    logic        rob_bp_correct;
    logic        sch_full;
    logic        tbl_req;
    logic        tbl_we;
    logic [3:0]  tbl_idx;
    logic [1:0]  tbl_wdata;
    logic [1:0]  tbl_rdata;
    logic [31:0] bp_total_cnt;
    logic [31:0] bp_correct_cnt;

    logic [1:0]  mem [16];
    int          err_cnt;
    int          chk_cnt;
    int          nwr;
    logic [3:0]  wr_idx_log [8];
    logic [1:0]  wr_val_log [8];

    bp_update_scheduler #(.DEPTH(4), .IDXW(4), .STARVE_LIMIT(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .fet_req(fet_req), .fet_pc(fet_pc), .fet_gnt(fet_gnt),
        .rob_bp_enable(rob_bp_enable), .rob_bp_inst_addr(rob_bp_inst_addr),
        .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct),
        .sch_full(sch_full), .tbl_req(tbl_req), .tbl_we(tbl_we),
        .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
        .bp_total_cnt(bp_total_cnt), .bp_correct_cnt(bp_correct_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port table: write at the edge, read data one cycle later.
    always @(posedge clk) begin
        if (tbl_req) begin
            if (tbl_we) mem[tbl_idx] <= tbl_wdata;
            else        tbl_rdata    <= mem[tbl_idx];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One uncontended update: push at N, read at N+1, write at N+2.
    task automatic do_update(input logic [31:0] pc, input logic jump, input logic corr,
                             input logic [1:0] exp_w);
        logic [3:0] idx;
        idx = pc[4:1];
        rob_bp_enable = 1'b1; rob_bp_inst_addr = pc; rob_bp_jump = jump; rob_bp_correct = corr;
        @(negedge clk);
        check_eq("upd_push_open", {31'd0, sch_full}, 32'd0);
        cyc();
        rob_bp_enable = 1'b0;
        @(negedge clk);
        check_eq("upd_read", {26'd0, tbl_req, tbl_we, idx}, {26'd0, 1'b1, 1'b0, idx});
        cyc();
        @(negedge clk);
        check_eq("upd_write", {24'd0, tbl_req, tbl_we, tbl_wdata, tbl_idx},
                 {24'd0, 1'b1, 1'b1, exp_w, idx});
        cyc();
        check_eq("upd_table", {30'd0, mem[idx]}, {30'd0, exp_w});
    endtask

    // Sweep check: 16 writes of 01, optional rdy pause at index 5.
    task automatic check_sweep(input logic pause);
        for (int i = 0; i < 16; i++) begin
            if (pause && i == 5) begin
                rdy = 1'b0;
                @(negedge clk);
                check_eq("rdy_low_idle", {30'd0, tbl_req, fet_gnt}, 32'd0);
                cyc();
                rdy = 1'b1;
            end
            @(negedge clk);
            check_eq("sweep", {24'd0, tbl_req, tbl_we, fet_gnt, sch_full, tbl_wdata, tbl_idx},
                     {24'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'(i)});
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        err_cnt = 0; chk_cnt = 0;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; fet_req = 1'b0; fet_pc = 32'h1E;
        rob_bp_enable = 1'b0; rob_bp_inst_addr = 32'd0; rob_bp_jump = 1'b0; rob_bp_correct = 1'b0;

        // Reset outputs
        @(negedge clk);
        check_eq("rst_outs", {24'd0, tbl_req, tbl_we, fet_gnt, sch_full, tbl_idx},
                 {24'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0});
        cyc();
        rst = 1'b0;
        check_eq("rst_total", bp_total_cnt, 32'd0);
        check_eq("rst_correct", bp_correct_cnt, 32'd0);

        // Reset sweep with fetch requesting throughout
        fet_req = 1'b1;
        check_sweep(1'b0);
        @(negedge clk);
        check_eq("post_sweep", {24'd0, sch_full, fet_gnt, tbl_we, 1'b0, tbl_idx},
                 {24'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15});
        fet_req = 1'b0;
        cyc();

        // Taken updates on idx 3: 01 -> 10 -> 11 -> 11
        do_update(32'd6, 1'b1, 1'b1, 2'b10);
        do_update(32'd6, 1'b1, 1'b1, 2'b11);
        do_update(32'd6, 1'b1, 1'b1, 2'b11);
        // Not-taken: idx 5 01 -> 00 -> 00; idx 3 11 -> 10 -> 01
        do_update(32'd10, 1'b0, 1'b0, 2'b00);
        do_update(32'd10, 1'b0, 1'b0, 2'b00);
        do_update(32'd6, 1'b0, 1'b0, 2'b10);
        do_update(32'd6, 1'b0, 1'b0, 2'b01);

        // Starvation: fetch idx 15 (01) held high, update idx 5 (00) taken -> 01
        fet_req = 1'b1; fet_pc = 32'h1E;
        rob_bp_enable = 1'b1; rob_bp_inst_addr = 32'd10; rob_bp_jump = 1'b1; rob_bp_correct = 1'b1;
        @(negedge clk);
        check_eq("stv_nopend_gnt", {31'd0, fet_gnt}, 32'd1);
        cyc();
        rob_bp_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stv_fetch_rd", {26'd0, fet_gnt, tbl_we, tbl_idx}, {26'd0, 1'b1, 1'b0, 4'd15});
            cyc();
        end
        @(negedge clk);
        check_eq("stv_read_stolen", {25'd0, fet_gnt, tbl_req, tbl_we, tbl_idx},
                 {25'd0, 1'b0, 1'b1, 1'b0, 4'd5});
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stv_fetch_wr", {26'd0, fet_gnt, tbl_we, tbl_idx}, {26'd0, 1'b1, 1'b0, 4'd15});
            cyc();
        end
        @(negedge clk);
        check_eq("stv_write_stolen", {23'd0, fet_gnt, tbl_req, tbl_we, tbl_wdata, tbl_idx},
                 {23'd0, 1'b0, 1'b1, 1'b1, 2'b01, 4'd5});
        cyc();

        // Backpressure: four pushes idx 8..11 fill the FIFO with fetch high
        for (int k = 0; k < 4; k++) begin
            rob_bp_enable = 1'b1; rob_bp_inst_addr = 32'(16 + 2 * k);
            rob_bp_jump = 1'b1; rob_bp_correct = (k % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            check_eq("bp_push_open", {31'd0, sch_full}, 32'd0);
            cyc();
        end
        rob_bp_inst_addr = 32'd24; rob_bp_correct = 1'b1;
        @(negedge clk);
        check_eq("bp_full", {31'd0, sch_full}, 32'd1);
        cyc();
        // Flushed pushes during the drain must all be dropped
        flush = 1'b1;
        nwr = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (tbl_req && tbl_we) begin
                if (nwr < 8) begin
                    wr_idx_log[nwr] = tbl_idx;
                    wr_val_log[nwr] = tbl_wdata;
                end
                nwr++;
            end
            cyc();
        end
        rob_bp_enable = 1'b0; flush = 1'b0; fet_req = 1'b0;
        check_eq("bp_write_count", 32'(nwr), 32'd4);
        for (int k = 0; k < 4; k++)
            check_eq("bp_write", {26'd0, wr_val_log[k], wr_idx_log[k]}, {26'd0, 2'b10, 4'(8 + k)});
        @(negedge clk);
        check_eq("bp_drained", {31'd0, sch_full}, 32'd0);
        cyc();
`ifdef BP_STATS_EN
        check_eq("stats_total", bp_total_cnt, 32'd12);
        check_eq("stats_correct", bp_correct_cnt, 32'd6);
`else
        check_eq("stats_total", bp_total_cnt, 32'd0);
        check_eq("stats_correct", bp_correct_cnt, 32'd0);
`endif

        // Reset in WR: update idx 6 is dropped and the sweep restarts
        rob_bp_enable = 1'b1; rob_bp_inst_addr = 32'd12; rob_bp_jump = 1'b1; rob_bp_correct = 1'b1;
        @(negedge clk);
        cyc();
        rob_bp_enable = 1'b0;
        @(negedge clk);
        check_eq("mid_read", {26'd0, tbl_req, tbl_we, tbl_idx}, {26'd0, 1'b1, 1'b0, 4'd6});
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_outs", {22'd0, tbl_req, tbl_we, fet_gnt, sch_full, tbl_wdata, tbl_idx},
                 {22'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'd0});
        cyc();
        rst = 1'b0;
        fet_req = 1'b1;
        check_sweep(1'b1);
        fet_req = 1'b0;
        @(negedge clk);
        check_eq("mid_empty", {30'd0, sch_full, tbl_req}, 32'd0);
        check_eq("mid_table", {30'd0, mem[6]}, {30'd0, 2'b01});
        check_eq("mid_stats", bp_total_cnt, 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
